// File: rtl/csa_accum_sequencer_if.sv
// Operand-stream and result handshake bundle for csa_accum_sequencer.
// master = operand source / result sink, slave = sequencer.
interface csa_accum_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_a;
  logic [IN_W-1:0]  in_b;
  logic             in_b_en;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_cnt_sat;

  modport master (
    output in_valid, in_a, in_b, in_b_en, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_cnt_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_b_en, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_cnt_sat
  );
endinterface

// File: rtl/csa_accum_sequencer.sv
// Multi-operand accumulator: redundant S/C/D state folded through a row of 5:3
// counters, resolved by one carry-propagate add at end of stream.

// Per-bit 5:3 counter: popcount of five equal-weight bits as {cout, carry, sum}.
module csa_5to3 (
  input  logic [4:0] x,
  output logic       s,
  output logic       c,
  output logic       co
);
  logic [2:0] n;

  always_comb begin
    n = '0;
    for (int k = 0; k < 5; k++) n = n + 3'(x[k]);
  end

  assign s  = n[0];
  assign c  = n[1];
  assign co = n[2];
endmodule

module csa_accum_sequencer #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   abort,
  csa_accum_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_RESOLVE, ST_OUT} state_t;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
  } res_t;

  state_t           state, nxt;
  logic [ACC_W-1:0] s_q, c_q, d_q;
  logic [ACC_W-1:0] s_n, cy, co;
  logic [ACC_W-1:0] a_x, b_x;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_sum;
  logic             sat_q, ovf;
  logic             rdy, accept, clr, resolve, vld;
  res_t             res_q;

  assign a_x = {{(ACC_W-IN_W){bus.in_a[IN_W-1]}}, bus.in_a};
  assign b_x = bus.in_b_en ? {{(ACC_W-IN_W){bus.in_b[IN_W-1]}}, bus.in_b} : '0;

  // One counter per accumulator bit; carries shift up one place, couts two.
  for (genvar i = 0; i < ACC_W; i++) begin : g_bit
    csa_5to3 u_cnt (
      .x  ({s_q[i], c_q[i], d_q[i], a_x[i], b_x[i]}),
      .s  (s_n[i]),
      .c  (cy[i]),
      .co (co[i])
    );
  end

  // in_ready must read low while reset is held even though state already sits in IDLE.
  assign rdy    = ~reset & (state == ST_IDLE || state == ST_ACCUM);
  assign accept = bus.in_valid & rdy & ~abort;

  // A beat carries one or two operands; sat marks that clamping actually happened.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'({bus.in_b_en, ~bus.in_b_en});
  assign ovf     = cnt_sum[CNT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    vld     = 1'b0;
    clr     = 1'b0;
    resolve = 1'b0;
    case (state)
      ST_IDLE:    if (accept) nxt = bus.in_last ? ST_RESOLVE : ST_ACCUM;
      ST_ACCUM:   if (accept && bus.in_last) nxt = ST_RESOLVE;
      ST_RESOLVE: begin
        resolve = 1'b1;
        nxt     = ST_OUT;
      end
      ST_OUT: begin
        vld = 1'b1;
        if (bus.out_ready) begin
          nxt = ST_IDLE;
          clr = 1'b1;
        end
      end
      default:    nxt = ST_IDLE;
    endcase
    if (abort) begin
      nxt     = ST_IDLE;
      clr     = 1'b1;
      resolve = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      s_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      s_q   <= s_n;
      c_q   <= cy << 1;
      d_q   <= co << 2;
      cnt_q <= ovf ? '1 : cnt_sum[CNT_W-1:0];
      sat_q <= sat_q | ovf;
    end
  end

  // Result registers only move on the resolve edge, so they hold through stalls and aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        res_q <= '0;
    else if (resolve) res_q <= '{data: s_q + c_q + d_q, count: cnt_q};
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = vld;
  assign bus.out_data    = res_q.data;
  assign bus.out_count   = res_q.count;
  assign bus.out_cnt_sat = sat_q;
endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Directed scoreboard bench for csa_accum_sequencer.
module tb_csa_accum_sequencer;
  localparam int IN_W  = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  csa_accum_sequencer_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_accum_sequencer #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .abort (abort),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             sat;
  } res_t;

  res_t             sb[$];
  logic [ACC_W-1:0] m_sum = '0;
  int               m_cnt = 0;
  int               n_chk = 0;
  int               n_bad = 0;

  function automatic logic [ACC_W-1:0] sx(input logic [IN_W-1:0] v);
    return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = '0;
    m_cnt = 0;
  endtask

  task automatic send(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                      input logic ben, input logic last);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_b_en  = ben;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("send_ready_timeout", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    m_sum += sx(a) + (ben ? sx(b) : '0);
    m_cnt += ben ? 2 : 1;
    if (last) begin
      sb.push_back(res_t'{data: m_sum,
                          count: (m_cnt > CMAX) ? CNT_W'(CMAX) : CNT_W'(m_cnt),
                          sat: (m_cnt > CMAX)});
      model_clear();
    end
  endtask

  task automatic wait_out(input string tag);
    int   g = 0;
    res_t e = '0;
    while (bus.out_valid !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, "_data"},  32'(bus.out_data),    32'(e.data));
    chk({tag, "_count"}, 32'(bus.out_count),   32'(e.count));
    chk({tag, "_sat"},   32'(bus.out_cnt_sat), 32'(e.sat));
  endtask

  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_valid_low"},  32'(bus.out_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_b_en   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    chk("rst_out_sat",   32'(bus.out_cnt_sat), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // 1: 1..10 as pairs, latency check
    for (int i = 0; i < 5; i++) send(8'(2*i+1), 8'(2*i+2), 1'b1, i == 4);
    chk("t1_lat_resolve", 32'(bus.out_valid), 0);
    chk("t1_resolve_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("t1_lat_out", 32'(bus.out_valid), 1);
    wait_out("t1");
    chk("t1_data_55", 32'(bus.out_data), 55);
    chk("t1_count_10", 32'(bus.out_count), 10);
    take("t1");

    // 2: single beat -128, B disabled
    send(8'h80, 8'h00, 1'b0, 1'b1);
    wait_out("t2");
    chk("t2_data_fff80", 32'(bus.out_data), 32'h000FFF80);
    chk("t2_count_1", 32'(bus.out_count), 1);
    take("t2");

    // 3: mixed signs, gaps, ignored in_last, B garbage when disabled, stall
    send(8'(100), 8'(-37), 1'b1, 1'b0);
    bus.in_last = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_last = 1'b0;
    chk("t3_lastnovalid_ready", 32'(bus.in_ready), 1);
    send(8'(-63), 8'(77), 1'b0, 1'b0);
    @(posedge clk); #1;
    send(8'(5), 8'(0), 1'b1, 1'b0);
    @(posedge clk); #1;
    send(8'(-5), 8'(99), 1'b0, 1'b1);
    wait_out("t3");
    chk("t3_data_0", 32'(bus.out_data), 0);
    chk("t3_count_6", 32'(bus.out_count), 6);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t3_stall_valid", 32'(bus.out_valid), 1);
      chk("t3_stall_ready", 32'(bus.in_ready), 0);
      chk("t3_stall_data",  32'(bus.out_data), 0);
      chk("t3_stall_count", 32'(bus.out_count), 6);
    end
    take("t3");

    // 4: counter saturation and mod 2^ACC_W wrap
    for (int i = 0; i < 4150; i++) send(8'(127), 8'(127), 1'b1, i == 4149);
    chk("t4_sat_live", 32'(bus.out_cnt_sat), 1);
    wait_out("t4");
    chk("t4_data_5524", 32'(bus.out_data), 5524);
    chk("t4_count_255", 32'(bus.out_count), 255);
    chk("t4_sat_1", 32'(bus.out_cnt_sat), 1);
    take("t4");
    chk("t4_sat_cleared", 32'(bus.out_cnt_sat), 0);

    // 5: abort alongside a beat, then new stream; abort during OUT
    send(8'(10), 8'(20), 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(50);
    bus.in_b_en  = 1'b0;
    bus.in_last  = 1'b1;
    abort        = 1'b1;
    @(posedge clk); #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    model_clear();
    chk("t5_abort_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    chk("t5_abort_no_out", 32'(bus.out_valid), 0);
    send(8'(3), 8'(4), 1'b1, 1'b1);
    wait_out("t5");
    chk("t5_data_7", 32'(bus.out_data), 7);
    chk("t5_count_2", 32'(bus.out_count), 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_out_abort_valid", 32'(bus.out_valid), 0);
    chk("t5_out_abort_data",  32'(bus.out_data), 7);
    chk("t5_out_abort_count", 32'(bus.out_count), 2);

    // 6: async reset mid-ACCUM and during OUT
    send(8'(5), 8'(6), 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_ready", 32'(bus.in_ready), 0);
    chk("t6_rst_data",  32'(bus.out_data), 0);
    chk("t6_rst_count", 32'(bus.out_count), 0);
    model_clear();
    #3 reset = 1'b0;
    @(posedge clk); #1;
    send(8'(9), 8'(-2), 1'b1, 1'b1);
    wait_out("t6");
    chk("t6_data_7", 32'(bus.out_data), 7);
    #3 reset = 1'b1;
    #1;
    chk("t6_out_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_out_rst_data",  32'(bus.out_data), 0);
    chk("t6_out_rst_count", 32'(bus.out_count), 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_post_rst_ready", 32'(bus.in_ready), 1);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
